// File: rtl/noc_port_vc_arbiter_pkg.sv
// ============================================================================
// Module  : noc_port_vc_arbiter_pkg
// Brief   : Shared types and constants for the per-port VC arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_port_vc_arbiter_pkg;

    localparam int Noc_VC_Channel     = 4;
    localparam int Noc_Arb_Stat_Width = 32;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } e_arb_state;

endpackage

`default_nettype wire

// File: rtl/noc_port_vc_arbiter_if.sv
// ============================================================================
// Module  : noc_port_vc_arbiter_if
// Brief   : Port control bundle between the route selector and the VC arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface noc_port_vc_arbiter_if
    import noc_port_vc_arbiter_pkg::*;
#(
    parameter int CHANNELS = Noc_VC_Channel
);

    logic [CHANNELS-1:0] request;
    logic [CHANNELS-1:0] free;
    logic [CHANNELS-1:0] start_of_packet;
    logic [CHANNELS-1:0] end_of_packet;
    logic [CHANNELS-1:0] grant;
    logic                busy;

    modport master (
        output request, free, start_of_packet, end_of_packet,
        input  grant, busy
    );

    modport slave (
        input  request, free, start_of_packet, end_of_packet,
        output grant, busy
    );

endinterface

`default_nettype wire

// File: rtl/noc_port_vc_arbiter_rr_pick.sv
// ============================================================================
// Module  : noc_rr_pick
// Brief   : Combinational round-robin picker (rotate + priority encode).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_rr_pick
    import noc_port_vc_arbiter_pkg::*;
#(
    parameter  int CHANNELS  = Noc_VC_Channel,
    localparam int PTR_WIDTH = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0]  cand_i,
    input  logic [PTR_WIDTH-1:0] rr_ptr_i,
    output logic [CHANNELS-1:0]  pick_o,
    output logic [PTR_WIDTH-1:0] pick_idx_o,
    output logic                 pick_valid_o
);

    localparam int SUM_W = PTR_WIDTH + 1;

    logic [CHANNELS-1:0]  rot;
    logic [PTR_WIDTH-1:0] offset;
    logic [SUM_W-1:0]     sum;

    // Shifting the doubled vector rotates cand so rr_ptr lands at bit 0.
    assign rot = CHANNELS'({cand_i, cand_i} >> rr_ptr_i);

    always_comb begin
        pick_o       = '0;
        pick_idx_o   = '0;
        pick_valid_o = 1'b0;
        offset       = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset       = PTR_WIDTH'(i);
                pick_valid_o = 1'b1;
            end
        end
        sum = {1'b0, rr_ptr_i} + {1'b0, offset};
        if (sum >= SUM_W'(CHANNELS)) begin
            sum = sum - SUM_W'(CHANNELS);
        end
        pick_idx_o = sum[PTR_WIDTH-1:0];
        if (pick_valid_o) begin
            pick_o[pick_idx_o] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/noc_port_vc_arbiter.sv
// ============================================================================
// Module  : noc_port_vc_arbiter
// Brief   : Wormhole-locked round-robin VC grant for one output port.
//           Optional counters enabled by NOC_ARB_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_port_vc_arbiter
    import noc_port_vc_arbiter_pkg::*;
#(
    parameter  int CHANNELS  = Noc_VC_Channel,
    localparam int PTR_WIDTH = $clog2(CHANNELS)
) (
    input  logic                   noc_clk,
    input  logic                   noc_rst,
    noc_port_vc_arbiter_if.slave   port_if
`ifdef NOC_ARB_STATS_EN
    ,
    output logic [CHANNELS-1:0][Noc_Arb_Stat_Width-1:0] stat_pkts,
    output logic [Noc_Arb_Stat_Width-1:0]               stat_stall
`endif
);

    localparam int SUM_W = PTR_WIDTH + 1;

    e_arb_state           state_q, state_d;
    logic [CHANNELS-1:0]  grant_q, grant_d;
    logic [PTR_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                 busy_q;

    logic [CHANNELS-1:0]  cand;
    logic [CHANNELS-1:0]  cand_eff;
    logic [CHANNELS-1:0]  pick;
    logic [PTR_WIDTH-1:0] pick_idx;
    logic                 pick_valid;
    logic                 eop_granted;
    logic [SUM_W-1:0]     rr_next;
    logic [PTR_WIDTH-1:0] rr_adv;

    assign cand        = port_if.request & port_if.start_of_packet;
    // The releasing VC sits out its own release cycle.
    assign cand_eff    = (state_q == ARB_LOCKED) ? (cand & ~grant_q) : cand;
    assign eop_granted = |(port_if.end_of_packet & grant_q);

    noc_rr_pick #(
        .CHANNELS (CHANNELS)
    ) u_rr_pick (
        .cand_i       (cand_eff),
        .rr_ptr_i     (rr_ptr_q),
        .pick_o       (pick),
        .pick_idx_o   (pick_idx),
        .pick_valid_o (pick_valid)
    );

    always_comb begin
        rr_next = {1'b0, pick_idx} + SUM_W'(1);
        if (rr_next == SUM_W'(CHANNELS)) begin
            rr_next = '0;
        end
        rr_adv = rr_next[PTR_WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d  = ARB_LOCKED;
                    grant_d  = pick;
                    rr_ptr_d = rr_adv;
                end
            end
            ARB_LOCKED: begin
                if (eop_granted) begin
                    if (pick_valid) begin
                        grant_d  = pick;
                        rr_ptr_d = rr_adv;
                    end else begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= (state_d == ARB_LOCKED);
        end
    end

    assign port_if.grant = grant_q;
    assign port_if.busy  = busy_q;

`ifdef NOC_ARB_STATS_EN
    logic [CHANNELS-1:0][Noc_Arb_Stat_Width-1:0] stat_pkts_q;
    logic [Noc_Arb_Stat_Width-1:0]               stat_stall_q;
    logic                                        stall_ev;

    assign stall_ev = busy_q & |(grant_q & port_if.request & ~port_if.free);

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            stat_pkts_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (port_if.end_of_packet[i] && grant_q[i] && (stat_pkts_q[i] != '1)) begin
                    stat_pkts_q[i] <= stat_pkts_q[i] + 1'b1;
                end
            end
            if (stall_ev && (stat_stall_q != '1)) begin
                stat_stall_q <= stat_stall_q + 1'b1;
            end
        end
    end

    assign stat_pkts  = stat_pkts_q;
    assign stat_stall = stat_stall_q;
`else
    // Downstream ready only feeds the stall counter.
    logic unused_free;
    assign unused_free = ^port_if.free;
`endif

endmodule

`default_nettype wire
